spiflash_rom_bridge: RTL and testbench

SPI-flash slave that answers the management core's boot-flash reads from an on-chip ROM image held in BRAM. On the slave side it connects to Caravel's `flash_csb`, `flash_clk`, `flash_io0` and `flash_io1` pins. On the ROM side it drives the HLS-style `romcode_*` BRAM port that is loaded from the firmware hex file. All logic runs on `ap_clk`; the SPI pins are oversampled as data.

---
 rtl/spiflash_pkg.sv | 24 ++
 rtl/spi_edge_sampler.sv | 41 ++++
 rtl/spiflash_rom_bridge.sv | 219 +++++++++++++++++++++
 tb/tb_spiflash_rom_bridge.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/spiflash_pkg.sv
// spiflash_pkg: shared state, opcode and byte-lane helpers
// for the SPI-flash ROM bridge.
package spiflash_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_DUMMY,
    ST_DATA,
    ST_IGNORE
  } state_e;

  localparam logic [7:0] CMD_READ      = 8'h03;
  localparam logic [7:0] CMD_FAST_READ = 8'h0B;

  function automatic logic [7:0] lane_byte(
    input logic [31:0] w,
    input logic [1:0]  lane
  );
    return w[{lane, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/spi_edge_sampler.sv
// spi_edge_sampler: registers the SPI pins once on the block clock
// and derives spiclk edge pulses against the previous sample.
module spi_edge_sampler (
  input  logic clk_i,
  input  logic rst_i,
  input  logic csb_i,
  input  logic sclk_i,
  input  logic mosi_i,
  output logic cs_active_o,
  output logic rise_o,
  output logic fall_o,
  output logic mosi_o
);

  logic csb_q;
  logic sclk_q;
  logic sclk_prev_q;
  logic mosi_q;

  // csb resets low so the FSM, not this stage, decides when a select
  // cycle is legitimate after reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      csb_q       <= 1'b0;
      sclk_q      <= 1'b0;
      sclk_prev_q <= 1'b0;
      mosi_q      <= 1'b0;
    end else begin
      csb_q       <= csb_i;
      sclk_q      <= sclk_i;
      sclk_prev_q <= sclk_q;
      mosi_q      <= mosi_i;
    end
  end

  assign cs_active_o = ~csb_q;
  assign rise_o      = sclk_q & ~sclk_prev_q;
  assign fall_o      = ~sclk_q & sclk_prev_q;
  assign mosi_o      = mosi_q;

endmodule

// File: rtl/spiflash_rom_bridge.sv
// spiflash_rom_bridge: SPI-flash read slave (0x03 / 0x0B) serving
// bytes from a word-wide BRAM image with one-word prefetch.
module spiflash_rom_bridge
  import spiflash_pkg::*;
#(
  parameter int ADDR_BITS    = 24,
  parameter int DUMMY_CYCLES = 8,
  parameter int BRAM_LATENCY = 1
) (
  input  logic        ap_clk,
  input  logic        ap_rst,
  input  logic        csb,
  input  logic        spiclk,
  input  logic        io0,
  output logic        io1,
  output logic [31:0] romcode_Addr_A,
  output logic        romcode_EN_A,
  output logic [3:0]  romcode_WEN_A,
  output logic [31:0] romcode_Din_A,
  input  logic [31:0] romcode_Dout_A,
  output logic        romcode_Clk_A,
  output logic        romcode_Rst_A
);

  localparam int AW = ADDR_BITS;
  localparam int BL = BRAM_LATENCY;

  logic cs_active;
  logic rise;
  logic fall;
  logic mosi;

  spi_edge_sampler u_sampler (
    .clk_i       (ap_clk),
    .rst_i       (ap_rst),
    .csb_i       (csb),
    .sclk_i      (spiclk),
    .mosi_i      (io0),
    .cs_active_o (cs_active),
    .rise_o      (rise),
    .fall_o      (fall),
    .mosi_o      (mosi)
  );

  state_e          state_q, state_d;
  logic [4:0]      bitcnt_q, bitcnt_d;
  logic [AW-1:0]   shift_q, shift_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic            fast_q, fast_d;
  logic            first_q, first_d;
  logic            armed_q, armed_d;
  logic [31:0]     word_q, word_d;
  logic [31:0]     pref_q, pref_d;
  logic            en_q, en_d;
  logic [31:0]     raddr_q, raddr_d;
  logic            io1_q, io1_d;
  logic [BL-1:0]   pipe_q, pipe_d;

  logic [BL:0]     pipe_ext;
  logic [AW-1:0]   shifted;
  logic [AW-1:0]   next_addr;
  logic [7:0]      opcode;
  logic [7:0]      cur_byte;
  logic [1:0]      lane;
  logic            unused_msb;

  assign unused_msb = shift_q[AW-1];
  assign shifted    = {shift_q[AW-2:0], mosi};
  assign next_addr  = addr_q + AW'(1);
  assign opcode     = shifted[7:0];
  assign lane       = addr_q[1:0];
  assign cur_byte   = lane_byte(word_q, lane);
  assign pipe_ext   = {pipe_q, en_q};

  always_comb begin
    state_d  = state_q;
    bitcnt_d = bitcnt_q;
    shift_d  = shift_q;
    addr_d   = addr_q;
    fast_d   = fast_q;
    first_d  = first_q;
    word_d   = word_q;
    pref_d   = pref_q;
    en_d     = 1'b0;
    raddr_d  = raddr_q;
    io1_d    = io1_q;
    pipe_d   = pipe_ext[BL-1:0];
    // A new select cycle is only honoured once csb has been seen high.
    armed_d  = armed_q | ~cs_active;

    if (!cs_active) begin
      state_d  = ST_IDLE;
      io1_d    = 1'b0;
      bitcnt_d = '0;
      pipe_d   = '0;
      first_d  = 1'b0;
    end else begin
      if (pipe_q[BL-1]) begin
        if (first_q) begin
          word_d  = romcode_Dout_A;
          first_d = 1'b0;
        end else begin
          pref_d = romcode_Dout_A;
        end
      end

      unique case (state_q)
        ST_IDLE: begin
          if (armed_q) begin
            state_d  = ST_CMD;
            bitcnt_d = '0;
          end
        end
        ST_CMD: begin
          if (rise) begin
            shift_d  = shifted;
            bitcnt_d = bitcnt_q + 5'd1;
            if (bitcnt_q == 5'd7) begin
              bitcnt_d = '0;
              unique case (1'b1)
                (opcode == CMD_READ): begin
                  state_d = ST_ADDR;
                  fast_d  = 1'b0;
                end
                (opcode == CMD_FAST_READ): begin
                  state_d = ST_ADDR;
                  fast_d  = 1'b1;
                end
                default: state_d = ST_IGNORE;
              endcase
            end
          end
        end
        ST_ADDR: begin
          if (rise) begin
            shift_d  = shifted;
            bitcnt_d = bitcnt_q + 5'd1;
            if (bitcnt_q == 5'(AW - 1)) begin
              bitcnt_d = '0;
              addr_d   = shifted;
              en_d     = 1'b1;
              raddr_d  = 32'({shifted[AW-1:2], 2'b00});
              first_d  = 1'b1;
              if (fast_q && DUMMY_CYCLES > 0) state_d = ST_DUMMY;
              else                            state_d = ST_DATA;
            end
          end
        end
        ST_DUMMY: begin
          if (rise) begin
            bitcnt_d = bitcnt_q + 5'd1;
            if (bitcnt_q == 5'(DUMMY_CYCLES - 1)) begin
              bitcnt_d = '0;
              state_d  = ST_DATA;
            end
          end
        end
        ST_DATA: begin
          if (fall) begin
            io1_d    = cur_byte[~bitcnt_q[2:0]];
            bitcnt_d = bitcnt_q + 5'd1;
            if (bitcnt_q == 5'd0 && lane == 2'd3) begin
              en_d    = 1'b1;
              raddr_d = 32'({next_addr[AW-1:2], 2'b00});
            end
            if (bitcnt_q == 5'd7) begin
              bitcnt_d = '0;
              addr_d   = next_addr;
              if (lane == 2'd3) word_d = pref_q;
            end
          end
        end
        ST_IGNORE: io1_d = 1'b0;
        default:   state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      state_q  <= ST_IDLE;
      bitcnt_q <= '0;
      shift_q  <= '0;
      addr_q   <= '0;
      fast_q   <= 1'b0;
      first_q  <= 1'b0;
      armed_q  <= 1'b0;
      word_q   <= '0;
      pref_q   <= '0;
      en_q     <= 1'b0;
      raddr_q  <= '0;
      io1_q    <= 1'b0;
      pipe_q   <= '0;
    end else begin
      state_q  <= state_d;
      bitcnt_q <= bitcnt_d;
      shift_q  <= shift_d;
      addr_q   <= addr_d;
      fast_q   <= fast_d;
      first_q  <= first_d;
      armed_q  <= armed_d;
      word_q   <= word_d;
      pref_q   <= pref_d;
      en_q     <= en_d;
      raddr_q  <= raddr_d;
      io1_q    <= io1_d;
      pipe_q   <= pipe_d;
    end
  end

  assign io1            = io1_q;
  assign romcode_EN_A   = en_q;
  assign romcode_Addr_A = raddr_q;
  assign romcode_WEN_A  = 4'b0000;
  assign romcode_Din_A  = 32'h0;
  assign romcode_Clk_A  = ap_clk;
  assign romcode_Rst_A  = ap_rst;

endmodule

// File: tb/tb_spiflash_rom_bridge.sv
// tb_spiflash_rom_bridge: directed and random SPI reads checked
// against a byte-addressed image model and expected fetch list.
module tb_spiflash_rom_bridge;
  import spiflash_pkg::*;

  localparam int AW = 24;
  localparam int DC = 8;

  logic        ap_clk = 1'b0;
  logic        ap_rst = 1'b1;
  logic        csb    = 1'b1;
  logic        spiclk = 1'b0;
  logic        io0    = 1'b0;
  logic        io1;
  logic [31:0] addr_a;
  logic        en_a;
  logic [3:0]  wen_a;
  logic [31:0] din_a;
  logic [31:0] dout_a = 32'h0;
  logic        clk_a;
  logic        rst_a;

  int ncmp  = 0;
  int nfail = 0;
  logic [31:0] en_log[$];

  spiflash_rom_bridge dut (
    .ap_clk         (ap_clk),
    .ap_rst         (ap_rst),
    .csb            (csb),
    .spiclk         (spiclk),
    .io0            (io0),
    .io1            (io1),
    .romcode_Addr_A (addr_a),
    .romcode_EN_A   (en_a),
    .romcode_WEN_A  (wen_a),
    .romcode_Din_A  (din_a),
    .romcode_Dout_A (dout_a),
    .romcode_Clk_A  (clk_a),
    .romcode_Rst_A  (rst_a)
  );

  always #5 ap_clk = ~ap_clk;

  function automatic logic [31:0] img(input logic [29:0] w);
    if (w == 30'd0) return 32'h0000_0093;
    if (w == 30'd1) return 32'h1234_5678;
    return (32'(w) * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
  endfunction

  function automatic logic [7:0] ref_byte(input logic [AW-1:0] a);
    logic [31:0] w;
    w = img(30'(a >> 2));
    return w[8*a[1:0] +: 8];
  endfunction

  always @(posedge ap_clk) begin
    if (en_a === 1'b1) begin
      dout_a <= img(addr_a[31:2]);
      en_log.push_back(addr_a);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge ap_clk);
    #1;
  endtask

  task automatic bit_cyc(input logic b, output logic r);
    spiclk = 1'b0;
    io0    = b;
    tick(4);
    r      = io1;
    spiclk = 1'b1;
    tick(4);
  endtask

  task automatic send_bits(input logic [31:0] v, input int n);
    logic r;
    for (int i = n - 1; i >= 0; i--) bit_cyc(v[i], r);
  endtask

  task automatic recv_byte(output logic [7:0] b);
    logic r;
    for (int i = 7; i >= 0; i--) begin
      bit_cyc(1'b0, r);
      b[i] = r;
    end
  endtask

  task automatic cs_start;
    csb = 1'b0;
    tick(4);
  endtask

  task automatic cs_end;
    csb = 1'b1;
    tick(3);
    spiclk = 1'b0;
    tick(4);
  endtask

  task automatic do_read(input string tag, input logic [7:0] op,
                         input logic [AW-1:0] a, input int n);
    logic [7:0]    b;
    logic          r;
    logic          acc;
    logic [AW-1:0] ak;
    logic [AW-1:0] nx;
    logic [31:0]   exp_en[$];
    en_log.delete();
    cs_start();
    send_bits(32'(op), 8);
    send_bits(32'(a), AW);
    if (op == CMD_FAST_READ) begin
      acc = 1'b0;
      for (int i = 0; i < DC; i++) begin
        bit_cyc(1'b0, r);
        acc = acc | (r !== 1'b0);
      end
      chk({tag, "_dummy_io1"}, 32'(acc), 32'h0);
    end
    exp_en.push_back(32'({a[AW-1:2], 2'b00}));
    for (int k = 0; k < n; k++) begin
      ak = a + AW'(k);
      recv_byte(b);
      chk({tag, "_byte"}, 32'(b), 32'(ref_byte(ak)));
      if (ak[1:0] == 2'd3) begin
        nx = ak + AW'(1);
        exp_en.push_back(32'({nx[AW-1:2], 2'b00}));
      end
    end
    cs_end();
    chk({tag, "_en_count"}, 32'(en_log.size()), 32'(exp_en.size()));
    for (int i = 0; i < exp_en.size() && i < en_log.size(); i++)
      chk({tag, "_en_addr"}, en_log[i], exp_en[i]);
  endtask

  initial begin
    logic [7:0]    b;
    logic          r;
    logic          acc;
    logic [7:0]    op;
    logic [AW-1:0] a;
    int            n;

    tick(3);
    ap_rst = 1'b0;
    tick(2);
    chk("reset_io1", 32'(io1), 32'h0);
    chk("reset_en", 32'(en_a), 32'h0);
    chk("reset_addr", addr_a, 32'h0);
    chk("reset_state", 32'(dut.state_q), 32'(ST_IDLE));

    do_read("t1_read0", CMD_READ, 24'h000000, 8);
    do_read("t2_unaligned", CMD_READ, 24'h000002, 4);
    do_read("t3_fast", CMD_FAST_READ, 24'h000004, 1);

    en_log.delete();
    cs_start();
    send_bits(32'h9F, 8);
    acc = 1'b0;
    for (int i = 0; i < 32; i++) begin
      bit_cyc(1'b1, r);
      acc = acc | (r !== 1'b0);
    end
    chk("t4_ignore_io1", 32'(acc), 32'h0);
    cs_end();
    chk("t4_ignore_en", 32'(en_log.size()), 32'h0);
    do_read("t4_after", CMD_READ, 24'h000000, 1);

    cs_start();
    send_bits(32'(CMD_READ), 8);
    send_bits(32'h0, AW);
    for (int i = 7; i >= 5; i--) begin
      bit_cyc(1'b0, r);
      b[i] = r;
    end
    chk("t5_partial", 32'(b[7:5]), 32'h4);
    cs_end();
    do_read("t5_abort", CMD_READ, 24'h000004, 1);

    do_read("t6_wrap", CMD_READ, 24'hFFFFFE, 3);

    cs_start();
    send_bits(32'(CMD_READ), 8);
    send_bits(32'h4, AW);
    bit_cyc(1'b0, r);
    bit_cyc(1'b0, r);
    chk("t6_pre_rst_io1", 32'(io1), 32'(ref_byte(24'h4) >> 6) & 32'h1);
    ap_rst = 1'b1;
    tick(1);
    ap_rst = 1'b0;
    chk("t6_rst_io1", 32'(io1), 32'h0);
    chk("t6_rst_state", 32'(dut.state_q), 32'(ST_IDLE));
    acc = 1'b0;
    for (int i = 0; i < 8; i++) begin
      bit_cyc(1'b1, r);
      acc = acc | (r !== 1'b0);
    end
    chk("t6_held_io1", 32'(acc), 32'h0);
    chk("t6_held_state", 32'(dut.state_q), 32'(ST_IDLE));
    cs_end();
    do_read("t6_after_rst", CMD_READ, 24'h000000, 2);

    for (int it = 0; it < 8; it++) begin
      op = ($urandom_range(0, 1) == 0) ? CMD_READ : CMD_FAST_READ;
      a  = AW'($urandom);
      if (it == 7) a = 24'hFFFFFD;
      n  = $urandom_range(1, 6);
      do_read("rand", op, a, n);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             ncmp, nfail);
    $finish;
  end

endmodule
